fibo_seq_gen: RTL and testbench
===============================

Name: fibo_seq_gen

Overview:
Parametrised Fibonacci sequence engine, the next generation of the fixed-function Fibonacci controller/datapath FSM.
- Computes F(N) for a run-time term index N at WIDTH-bit precision.
- Start/Busy/Done handshake; per-run overflow detection.
- Sits as a compute slave under a host FSM or bench driver.

Parameters:
- WIDTH, 16, bit width of datapath and Result.
- NW, 6, bit width of the term index N (max N = 2^NW-1).

Ports:
- Clk  in  1  clock, all state updates on rising edge.
- Rst  in  1  reset; synchronous, active-high.
- Start  in  1  request; sampled only in IDLE.
- N  in  NW  term index; latched when Start is accepted.
- Busy  out  1  high from the cycle after Start acceptance until Done.
- Done  out  1  one-cycle pulse; Result and Overflow valid.
- Result  out  WIDTH  F(N) mod 2^WIDTH; held until next accepted Start.
- Overflow  out  1  F(N) >= 2^WIDTH; held with Result.
- Term  out  WIDTH  streamed term (optional feature).
- Term_valid  out  1  Term qualifier (optional feature).

Behaviour:
- Reset: Clk-synchronous, when Rst=1 at the edge.
  - State goes to IDLE.
  - Busy=0, Done=0, Result=0, Overflow=0, Term=0, Term_valid=0.
  - Internal A, B, cnt and ovf bits are all cleared.
  - Rst overrides Start and aborts any run in progress; no Done is produced for an aborted run.
- States: IDLE, CALC, DONE. All outputs are registered.
- IDLE:
  - On Start=1: A<=0 (F0), B<=1 (F1), A_ovf<=0, B_ovf<=0, cnt<=N; go to CALC; Busy<=1.
  - On Start=0: stay in IDLE; Busy=0.
- CALC:
  - If cnt==0: Result<=A, Overflow<=A_ovf, Done<=1, Busy<=0; go to DONE.
  - Else:
    - A<=B and A_ovf<=B_ovf.
    - B<=(A+B)[WIDTH-1:0] and B_ovf<=carry_out|A_ovf|B_ovf.
    - cnt<=cnt-1.
- DONE: Done<=0; go to IDLE. Start is ignored in this state.
- Latency: Start accepted at edge k gives Done high after edge k+N+1.
  - N=0 gives Done after edge k+1.
  - Back-to-back throughput is one run per N+3 cycles.
- Start while Busy or in DONE: ignored, not queued. N changes outside the acceptance edge have no effect.
- Arithmetic and overflow:
  - Arithmetic is unsigned and wraps modulo 2^WIDTH.
  - Overflow reflects only the returned term. Overflow of the look-ahead register B while cnt reaches 0 does not set Overflow.
- Result and Overflow persist across IDLE until the next accepted Start; they are not cleared at acceptance.

Optional Feature:
- Macro: FIBO_TERM_STREAM_EN.
- Defined:
  - Each CALC cycle drives Term<=A and Term_valid<=1, including the cnt==0 cycle.
  - This emits F(0)..F(N) in order, N+1 beats, with the last beat coincident with Done.
  - Term_valid=0 in IDLE and DONE.
- Undefined:
  - Term and Term_valid are tied to constant 0.
  - No streaming logic is synthesised.
  - Ports remain present so the interface is unchanged.

Decomposition:
- Package fibo_pkg holds:
  - state encoding localparams (IDLE/CALC/DONE);
  - seed constants FIBO_SEED0=0 and FIBO_SEED1=1.
- Sub-module fibo_datapath holds:
  - A/B registers, adder, and A_ovf/B_ovf bits;
  - controls from the parent: load, step.
- fibo_seq_gen holds the FSM, cnt, and output registers.

Test Plan (WIDTH=16, NW=6):
- Rst=1 for 2 cycles with Start=1, then deassert → no run starts during Rst; all outputs 0 after reset; Busy rises only after the first post-reset Start edge.
- N=0, Start pulse → Done after 1 cycle, Result=0, Overflow=0. Then N=1 → Done after 2 cycles, Result=1.
- N=10 → Done exactly 11 cycles after acceptance, Result=55. With FIBO_TERM_STREAM_EN: 11 beats 0,1,1,2,3,5,8,13,21,34,55.
- N=24 → Result=46368, Overflow=0 (B wraps at F(25) but is unused). N=25 → Result=9489 (75025 mod 65536), Overflow=1.
- Start held high for 40 cycles with N=5 → Result=5 on every Done; Done pulses spaced 8 cycles; Start during Busy/DONE ignored.
- N=20 started, Rst asserted at cycle 7 → next edge returns all outputs to 0 with no Done; new Start with N=3 → Result=2.

Source files
------------

// File: rtl/fibo_pkg.sv
// Shared definitions for the Fibonacci sequence engine: FSM state encoding and sequence seeds.
package fibo_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CALC = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    typedef enum logic [1:0] {
        IDLE = ST_IDLE,
        CALC = ST_CALC,
        DONE = ST_DONE
    } state_t;

    localparam int unsigned FIBO_SEED0 = 0;
    localparam int unsigned FIBO_SEED1 = 1;

endpackage

// File: rtl/fibo_datapath.sv
// Fibonacci term registers: A holds F(i), B holds the look-ahead F(i+1); each carries a sticky
// "true value no longer fits in WIDTH bits" flag.
module fibo_datapath
    import fibo_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             step,
    output logic [WIDTH-1:0] a,
    output logic             a_ovf
);

    logic [WIDTH-1:0] b;
    logic             b_ovf;
    logic [WIDTH:0]   sum;

    assign sum = {1'b0, a} + {1'b0, b};

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            a     <= '0;
            b     <= '0;
            a_ovf <= 1'b0;
            b_ovf <= 1'b0;
        end else if (load) begin
            a     <= WIDTH'(FIBO_SEED0);
            b     <= WIDTH'(FIBO_SEED1);
            a_ovf <= 1'b0;
            b_ovf <= 1'b0;
        end else if (step) begin
            a     <= b;
            a_ovf <= b_ovf;
            b     <= sum[WIDTH-1:0];
            // Once a term has overflowed every later term is also too large.
            b_ovf <= sum[WIDTH] | a_ovf | b_ovf;
        end
    end

endmodule

// File: rtl/fibo_seq_gen.sv
// Fibonacci sequence engine: computes F(n) mod 2^WIDTH with a start/busy/done handshake.
// Optional term streaming is enabled by defining FIBO_TERM_STREAM_EN.
module fibo_seq_gen
    import fibo_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int NW    = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [NW-1:0]    n,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             overflow,
    output logic [WIDTH-1:0] term,
    output logic             term_valid
);

    state_t           state, state_nxt;
    logic [NW-1:0]    cnt;
    logic             load, step, finish;
    logic [WIDTH-1:0] a;
    logic             a_ovf;

    fibo_datapath #(.WIDTH(WIDTH)) u_datapath (
        .clk   (clk),
        .rst   (rst),
        .load  (load),
        .step  (step),
        .a     (a),
        .a_ovf (a_ovf)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // NOTE: defaults assigned first so no path through the case leaves a signal unassigned (no latches).
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = CALC;
            CALC:    if (cnt == '0) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        load   = 1'b0;
        step   = 1'b0;
        finish = 1'b0;
        case (state)
            IDLE: load = start;
            CALC: begin
                finish = (cnt == '0);
                step   = (cnt != '0);
            end
            default: ;
        endcase
    end

    // Result/overflow are only written on finish, so they persist through idle time.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt      <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            result   <= '0;
            overflow <= 1'b0;
        end else begin
            done <= 1'b0;
            if (load) begin
                cnt  <= n;
                busy <= 1'b1;
            end
            if (step) cnt <= cnt - NW'(1);
            if (finish) begin
                result   <= a;
                overflow <= a_ovf;
                done     <= 1'b1;
                busy     <= 1'b0;
            end
        end
    end

`ifdef FIBO_TERM_STREAM_EN
    // Every CALC cycle emits A, so F(0)..F(n) appear with the last beat alongside done.
    always_ff @(posedge clk) begin
        if (rst) begin
            term       <= '0;
            term_valid <= 1'b0;
        end else begin
            term_valid <= (state == CALC);
            if (state == CALC) term <= a;
        end
    end
`else
    assign term       = '0;
    assign term_valid = 1'b0;
`endif

endmodule

// File: tb/tb_fibo_seq_gen.sv
// Self-checking bench for fibo_seq_gen: a timeline model of accepted runs checked every cycle,
// plus directed runs with hand-computed results and latencies.
module tb_fibo_seq_gen;

    localparam int WIDTH = 16;
    localparam int NW    = 6;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start = 1'b0;
    logic [NW-1:0]    n = '0;
    logic             busy, done, overflow, term_valid;
    logic [WIDTH-1:0] result, term;

    fibo_seq_gen #(.WIDTH(WIDTH), .NW(NW)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .n          (n),
        .busy       (busy),
        .done       (done),
        .result     (result),
        .overflow   (overflow),
        .term       (term),
        .term_valid (term_valid)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    // Exact Fibonacci value; F(63) fits comfortably in 64 bits.
    function automatic logic [63:0] fib(input int k);
        logic [63:0] x = 0, y = 1, t;
        for (int i = 0; i < k; i++) begin
            t = x + y;
            x = y;
            y = t;
        end
        return x;
    endfunction

    function automatic logic [WIDTH-1:0] fib_mod(input int k);
        logic [63:0] f = fib(k);
        return f[WIDTH-1:0];
    endfunction

    function automatic logic fib_ovf(input int k);
        return fib(k) >= (64'd1 << WIDTH);
    endfunction

    // Timeline model: a run accepted at edge t with index n finishes at edge t+n+1, streams
    // F(edge-t-1) on each edge in between, and the next start can be accepted two edges after done.
    int               cyc = 0;
    int               t_acc = 0;
    int               n_lat = 0;
    int               free_at = 0;
    bit               active = 0;
    bit               model_on = 0;
    logic             e_busy, e_done, e_ovf, e_tv;
    logic [WIDTH-1:0] e_result, e_term;

    always @(posedge clk) begin
        cyc++;
        if (rst) begin
            model_on = 1;
            active   = 0;
            free_at  = cyc + 1;
            e_busy = 0; e_done = 0; e_ovf = 0; e_tv = 0;
            e_result = '0; e_term = '0;
        end else begin
            e_done = 0;
            e_tv   = 0;
            if (active) begin
                e_term = fib_mod(cyc - t_acc - 1);
                e_tv   = 1;
                if (cyc - t_acc - 1 == n_lat) begin
                    e_done   = 1;
                    e_busy   = 0;
                    e_result = fib_mod(n_lat);
                    e_ovf    = fib_ovf(n_lat);
                    active   = 0;
                    free_at  = cyc + 2;
                end
            end else if (start && cyc >= free_at) begin
                active = 1;
                t_acc  = cyc;
                n_lat  = int'(n);
                e_busy = 1;
            end
        end
    end

    always @(negedge clk) begin
        if (model_on) begin
            check("cyc_busy", busy, e_busy);
            check("cyc_done", done, e_done);
            check("cyc_result", result, e_result);
            check("cyc_overflow", overflow, e_ovf);
`ifdef FIBO_TERM_STREAM_EN
            check("cyc_term_valid", term_valid, e_tv);
            if (e_tv) check("cyc_term", term, e_term);
`else
            check("cyc_term_valid", term_valid, 0);
            check("cyc_term", term, 0);
`endif
        end
    end

    logic [WIDTH-1:0] beats[$];
    always @(negedge clk) if (term_valid === 1'b1) beats.push_back(term);

    // Counts negedges after the acceptance edge until done is seen (bounded).
    task automatic wait_done(output int lat);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (done !== 1'b1 && lat < 200);
    endtask

    task automatic run(input int nv, input logic [63:0] exp_res, input logic exp_ovf, input string tag);
        int lat;
        @(negedge clk);
        n = NW'(nv);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = ~n;  // index changes after acceptance must not matter
        wait_done(lat);
        check({tag, "_latency"}, lat, nv + 1);
        check({tag, "_result"}, result, exp_res);
        check({tag, "_overflow"}, overflow, exp_ovf);
    endtask

    initial begin
        int lat;
        int stamps[$];
        int seen;
        int exp_beats[11] = '{0, 1, 1, 2, 3, 5, 8, 13, 21, 34, 55};

        // Pin the model against hand-computed values.
        check("model_f10", fib_mod(10), 55);
        check("model_f24", fib_mod(24), 46368);
        check("model_f25", fib_mod(25), 9489);
        check("model_ovf24", fib_ovf(24), 0);
        check("model_ovf25", fib_ovf(25), 1);

        // Reset held with start asserted: nothing may start.
        rst = 1'b1; start = 1'b1; n = 6'd5;
        repeat (2) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_result", result, 0);
        check("rst_overflow", overflow, 0);
        check("rst_term_valid", term_valid, 0);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_busy", busy, 1);
        start = 1'b0;
        wait_done(lat);
        check("first_latency", lat, 6);
        check("first_result", result, 5);

        run(0, 0, 0, "n0");
        run(1, 1, 0, "n1");
        beats.delete();
        run(10, 55, 0, "n10");
`ifdef FIBO_TERM_STREAM_EN
        check("stream_beats", beats.size(), 11);
        foreach (exp_beats[i]) if (i < beats.size()) check("stream_beat", beats[i], exp_beats[i]);
`endif
        run(24, 46368, 0, "n24");
        run(25, 9489, 1, "n25");

        // Start held high: runs spaced n+3 cycles, extra starts ignored.
        @(negedge clk);
        n = 6'd5;
        start = 1'b1;
        repeat (40) begin
            @(negedge clk);
            if (done === 1'b1) begin
                stamps.push_back(cyc);
                check("held_result", result, 5);
            end
        end
        start = 1'b0;
        check("held_count", stamps.size(), 5);
        for (int i = 1; i < stamps.size(); i++) check("held_spacing", stamps[i] - stamps[i-1], 8);
        repeat (3) @(negedge clk);

        // Abort a long run with reset.
        n = 6'd20;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (6) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_result", result, 0);
        check("abort_overflow", overflow, 0);
        seen = 0;
        repeat (25) begin
            @(negedge clk);
            if (done === 1'b1) seen++;
        end
        check("abort_no_done", seen, 0);
        run(3, 2, 0, "n3");

        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
